// File: rtl/fetch_pkg.sv
// fetch_pkg: types and line geometry shared by the fetch FSM and the instruction unpacker.
package fetch_pkg;
  typedef enum logic [1:0] {EMPTY, DRAIN, HALTED} unpack_state_t;
  localparam int LINE_BYTES = 64;
  localparam int INSTRS_PER_LINE = 16;
  localparam int LINE_OFFSET_BITS = 6;
endpackage

// File: rtl/line_word_mux.sv
// line_word_mux: selects one instruction word of a cache line by index.
module line_word_mux import fetch_pkg::*; #(
  parameter int LINE_WIDTH = 512,
  parameter int INSTR_WIDTH = 32
) (
  input  logic [LINE_WIDTH-1:0]  line,
  input  logic [3:0]             idx,
  output logic [INSTR_WIDTH-1:0] word
);
  logic [INSTR_WIDTH-1:0] words [INSTRS_PER_LINE];
  for (genvar i = 0; i < INSTRS_PER_LINE; i++) begin : g_word
    assign words[i] = line[i*INSTR_WIDTH +: INSTR_WIDTH];
  end
  assign word = words[idx];
endmodule

// File: rtl/instr_line_unpacker.sv
// instr_line_unpacker: holds one fetched line and emits its instructions one per cycle with their PCs.
module instr_line_unpacker import fetch_pkg::*; #(
  parameter int LINE_WIDTH = 512,
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_valid,
  output logic                   line_ready,
  input  logic [LINE_WIDTH-1:0]  line_data,
  input  logic [ADDR_WIDTH-1:0]  line_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic [ADDR_WIDTH-1:0]  next_line_pc,
  input  logic                   flush,
  output logic                   halt
);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  unpack_state_t state;
  logic [LINE_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0] base;
  logic [3:0] idx;
  logic [INSTR_WIDTH-1:0] word;
  logic zero, fire, accept;
  line_word_mux #(.LINE_WIDTH(LINE_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) u_mux (
    .line(line_q),
    .idx (idx),
    .word(word)
  );
  assign zero = word == '0;
  assign instr = word;
  assign instr_pc = base + ADDR_WIDTH'({idx, 2'b00});
  assign instr_valid = state == DRAIN && !zero && !flush;
  assign fire = instr_valid && instr_ready;
  // the last word's handshake frees the buffer in the same cycle, so a waiting line loads with no bubble
  assign line_ready = !reset && !flush && (state == EMPTY || (idx == 4'hF && fire));
  assign accept = line_valid && line_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      line_q <= '0;
      base <= '0;
      idx <= '0;
      halt <= 1'b0;
      next_line_pc <= '0;
    end else if (flush && state != HALTED) begin
      state <= EMPTY;
    end else if (accept) begin
      line_q <= line_data;
      base <= line_pc & LINE_MASK;
      idx <= line_pc[LINE_OFFSET_BITS-1:2];
      next_line_pc <= (line_pc & LINE_MASK) + ADDR_WIDTH'(LINE_BYTES);
      state <= DRAIN;
    end else if (state == DRAIN && zero) begin
      state <= HALTED;
      halt <= 1'b1;
    end else if (fire) begin
      idx <= idx + 4'd1;
      state <= idx == 4'hF ? EMPTY : DRAIN;
    end
  end
endmodule

// File: doc/instr_line_unpacker.md
# instr_line_unpacker

Splits each 512-bit cache line assembled by the fetch bus state machine into sixteen 32-bit instructions and hands them, one per cycle, with their PCs, to the decoder over a valid/ready handshake. It sits between the fetch stage and the decoder, holds one line, and accepts the next line in the same cycle the last instruction of the current line is consumed. It also reports the next sequential line address back to fetch. It detects the all-zero end-of-program word and raises a sticky halt.

## Interface
- LINE_WIDTH, 512, bits per fetched line (8 bus beats of 64)
- INSTR_WIDTH, 32, bits per instruction
- ADDR_WIDTH, 64, PC width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- line_valid  in  1  fetch presents a complete line
- line_ready  out  1  unpacker accepts the line this cycle
- line_data  in  LINE_WIDTH  line; word k is at line_data[32k +: 32], beat i is at [64i +: 64]
- line_pc  in  ADDR_WIDTH  PC of the first instruction to emit; need not be line-aligned
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decoder consumes this cycle
- instr  out  INSTR_WIDTH  current instruction
- instr_pc  out  ADDR_WIDTH  PC of instr
- next_line_pc  out  ADDR_WIDTH  (line_pc & ~63) + 64 of the last accepted line
- flush  in  1  discard buffered line (redirect)
- halt  out  1  sticky; zero instruction reached

## Operation
- States: EMPTY, DRAIN, HALTED.
- EMPTY: line_ready=1. On line_valid: latch line_data. Set base = line_pc & ~63. Set idx = line_pc[5:2]. Go to DRAIN.
- DRAIN: instr = word[idx]; instr_pc = base + 4*idx; instr_valid=1 unless word[idx]==0.
- DRAIN handshake (instr_valid & instr_ready):
  - idx<15: idx++.
  - idx==15: go to EMPTY, or reload immediately (next bullet).
- line_ready in DRAIN = (idx==15) & instr_valid & instr_ready. A line presented that cycle is latched as in EMPTY, and the state stays DRAIN.
- instr/instr_pc stay stable while instr_valid & !instr_ready.
- Zero word in DRAIN: instr_valid=0, halt=1 next cycle, go to HALTED. Only reset leaves HALTED. line_ready=0 and instr_valid=0 in HALTED; flush is ignored.
- flush (EMPTY or DRAIN): highest priority. Go to EMPTY next cycle, line_ready=0 and instr_valid=0 that cycle, no handshake counted, line_valid ignored.
- idx is 4 bits; 15->0 wrap occurs only via reload. PC arithmetic is modulo 2^64.

## Timing
- Reset values: state EMPTY, idx 0, halt 0, instr_valid 0, instr 0, instr_pc 0, next_line_pc 0. line_ready=0 while reset is high and 1 the cycle after.
- Latency: line accepted at edge N -> instr_valid high in cycle N+1.
- Throughput: 1 instr/cycle, including across line boundaries when fetch has the next line ready.
- line_ready depends combinationally on instr_ready. instr_valid does not depend on instr_ready.
- next_line_pc updates at the edge that accepts a line.
- Reset mid-DRAIN drops the line, with no instruction emitted afterwards.

## Structure
- Shared package fetch_pkg:
  - state enum unpack_state_t {EMPTY, DRAIN, HALTED}
  - LINE_BYTES=64, INSTRS_PER_LINE=16, LINE_OFFSET_BITS=6
- Shared with the fetch FSM.
- One sub-module, line_word_mux: combinational 16:1 selection of the 32-bit word by idx.

## Test plan
- Aligned line: line_pc=0x1000, words 0x00000013+k (k=0..15), instr_ready=1 -> 16 consecutive instrs, PCs 0x1000..0x103C, next_line_pc=0x1040.
- Unaligned entry: line_pc=0x1028 -> first instr is word 10 at PC 0x1028, 6 instrs total, then line_ready=1.
- Back-pressure and back-to-back lines:
  - Toggle instr_ready 1,0,0,1 -> instr is held stable while stalled, no duplicates or skips.
  - Second line valid at idx 15 -> accepted the same cycle, with no bubble between PC 0x103C and 0x1040.
- Halt: word 3 = 0 -> instrs 0..2 emitted, instr_valid never high for word 3, halt=1 from the next cycle. It persists through flush and clears only on reset.
- Flush and reset:
  - flush at idx 5 with line_valid=1 -> no handshake that cycle, EMPTY next cycle, new line then accepted.
  - reset mid-DRAIN -> all outputs at reset values the next cycle.
